// File: rtl/intt_ctrl.sv
// Sequencer for an in-place 256-point Kyber inverse NTT driving one external GS butterfly.
// Optional macro INTT_SCALE_EN adds a final pass that multiplies every coefficient by 128^-1.
module intt_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        rd_en,
  output logic [7:0]  rd_addr_a,
  output logic [7:0]  rd_addr_b,
  input  logic [11:0] rd_data_a,
  input  logic [11:0] rd_data_b,
  output logic        wr_en_a,
  output logic        wr_en_b,
  output logic [7:0]  wr_addr_a,
  output logic [7:0]  wr_addr_b,
  output logic [11:0] wr_data_a,
  output logic [11:0] wr_data_b,
  output logic [6:0]  zeta_idx,
  input  logic [11:0] zeta_data,
  output logic [11:0] bf_even,
  output logic [11:0] bf_odd,
  output logic [11:0] bf_zeta,
  input  logic [11:0] bf_even_out,
  input  logic [11:0] bf_odd_out
);

`ifdef INTT_SCALE_EN
  localparam logic [11:0] N_INV = 12'd3303;
  typedef enum logic [2:0] {StIdle, StLayer, StDrain, StScale, StSdrain, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StLayer, StDrain, StDone} state_e;
`endif

  state_e      state;
  logic [7:0]  cnt;    // butterfly index in a layer, coefficient index in the scale pass
  logic [2:0]  layer;
  logic [6:0]  k;
  logic        wr_scale;
  logic [7:0]  len;
  logic [7:0]  nxt_a;
  logic        grp_last;

  function automatic logic [7:0] even_addr(input logic [7:0] b, input logic [2:0] l);
    logic [3:0] sh;
    logic [7:0] m;
    sh = {1'b0, l} + 4'd1;
    m  = (8'd1 << sh) - 8'd1;
    return ((b >> sh) << (sh + 4'd1)) | (b & m);
  endfunction

  assign len      = 8'd2 << layer;
  assign nxt_a    = even_addr(cnt + 8'd1, layer);
  assign grp_last = ((cnt & (len - 8'd1)) == (len - 8'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_a <= 8'd0;
      rd_addr_b <= 8'd0;
      zeta_idx  <= 7'd0;
      wr_en_a   <= 1'b0;
      wr_en_b   <= 1'b0;
      wr_addr_a <= 8'd0;
      wr_addr_b <= 8'd0;
      cnt       <= 8'd0;
      layer     <= 3'd0;
      k         <= 7'd0;
`ifdef INTT_SCALE_EN
      wr_scale  <= 1'b0;
`endif
    end else begin
      done      <= 1'b0;
      // Write-back trails the issue by one cycle, matching the RAM read latency.
      wr_en_a   <= rd_en;
      wr_addr_a <= rd_addr_a;
      wr_addr_b <= rd_addr_b;
`ifdef INTT_SCALE_EN
      wr_en_b   <= rd_en & (state != StScale);
      wr_scale  <= (state == StScale);
`else
      wr_en_b   <= rd_en;
`endif
      unique case (state)
        StIdle: begin
          if (start) begin
            state     <= StLayer;
            busy      <= 1'b1;
            rd_en     <= 1'b1;
            rd_addr_a <= 8'd0;
            rd_addr_b <= 8'd2;
            zeta_idx  <= 7'd127;
            k         <= 7'd127;
            cnt       <= 8'd0;
            layer     <= 3'd0;
          end
        end
        StLayer: begin
          cnt <= cnt + 8'd1;
          if (grp_last) k <= k - 7'd1;
          if (cnt == 8'd127) begin
            state     <= StDrain;
            rd_en     <= 1'b0;
            rd_addr_a <= 8'd0;
            rd_addr_b <= 8'd0;
            zeta_idx  <= 7'd0;
            cnt       <= 8'd0;
          end else begin
            rd_addr_a <= nxt_a;
            rd_addr_b <= nxt_a + len;
            zeta_idx  <= grp_last ? k - 7'd1 : k;
          end
        end
        StDrain: begin
          if (layer == 3'd6) begin
`ifdef INTT_SCALE_EN
            state     <= StScale;
            rd_en     <= 1'b1;
            rd_addr_a <= 8'd0;
            rd_addr_b <= 8'd0;
            cnt       <= 8'd0;
`else
            state     <= StDone;
            busy      <= 1'b0;
            done      <= 1'b1;
`endif
          end else begin
            state     <= StLayer;
            layer     <= layer + 3'd1;
            rd_en     <= 1'b1;
            rd_addr_a <= 8'd0;
            rd_addr_b <= 8'd4 << layer;
            zeta_idx  <= k;
            cnt       <= 8'd0;
          end
        end
`ifdef INTT_SCALE_EN
        StScale: begin
          if (cnt == 8'd255) begin
            state     <= StSdrain;
            rd_en     <= 1'b0;
            rd_addr_a <= 8'd0;
          end else begin
            cnt       <= cnt + 8'd1;
            rd_addr_a <= cnt + 8'd1;
          end
        end
        StSdrain: begin
          state <= StDone;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
`endif
        StDone:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

  // Datapath is steered only during write-back cycles; otherwise it is held at zero.
`ifdef INTT_SCALE_EN
  assign bf_even   = (wr_en_a && !wr_scale) ? rd_data_a : 12'd0;
  assign bf_odd    = !wr_en_a ? 12'd0 : (wr_scale ? rd_data_a : rd_data_b);
  assign bf_zeta   = !wr_en_a ? 12'd0 : (wr_scale ? N_INV : zeta_data);
  assign wr_data_a = !wr_en_a ? 12'd0 : (wr_scale ? bf_odd_out : bf_even_out);
`else
  assign wr_scale  = 1'b0;
  assign bf_even   = wr_en_a ? rd_data_a : 12'd0;
  assign bf_odd    = wr_en_a ? rd_data_b : 12'd0;
  assign bf_zeta   = wr_en_a ? zeta_data : 12'd0;
  assign wr_data_a = wr_en_a ? bf_even_out : 12'd0;
`endif
  assign wr_data_b = wr_en_b ? bf_odd_out : 12'd0;

endmodule

// File: doc/intt_ctrl.md
Name: intt_ctrl

Overview:
Sequencer that runs a full 256-point Kyber inverse NTT in place using one external Gentleman-Sande butterfly (`intt_butterfly`), which computes even_out = even+odd and odd_out = zeta*(odd-even) mod q.
- Walks 7 layers, len = 2,4,…,128, at one butterfly per cycle.
- Generates coefficient-RAM read/write addresses and the zeta ROM index, and routes data to and from the butterfly.
- Sits between the polynomial RAM (2R/2W, 1-cycle registered read), the zeta ROM (1-cycle registered read) and the butterfly.

Parameters:
- N_INV, 3303, 128^-1 mod 3329; used only by the optional scaling pass.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle request; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse on completion
- rd_en  out  1  RAM read strobe, both ports
- rd_addr_a  out  8  RAM read address, port A (even)
- rd_addr_b  out  8  RAM read address, port B (odd)
- rd_data_a  in  12  port A data, valid 1 cycle after rd_en
- rd_data_b  in  12  port B data, valid 1 cycle after rd_en
- wr_en_a  out  1  RAM write enable, port A
- wr_en_b  out  1  RAM write enable, port B
- wr_addr_a  out  8  RAM write address, port A
- wr_addr_b  out  8  RAM write address, port B
- wr_data_a  out  12  RAM write data, port A
- wr_data_b  out  12  RAM write data, port B
- zeta_idx  out  7  zeta ROM address; data valid 1 cycle later
- zeta_data  in  12  zeta ROM data
- bf_even  out  12  butterfly even input
- bf_odd  out  12  butterfly odd input
- bf_zeta  out  12  butterfly zeta input
- bf_even_out  in  12  butterfly even result
- bf_odd_out  in  12  butterfly odd result

Behaviour:
- Reset: state IDLE; every output and internal counter is 0.
  - rst asserted mid-operation aborts. The next cycle is IDLE, with no write enables asserted.
  - RAM contents after an abort are undefined.
- States:
  - IDLE → LAYER on start.
  - LAYER → DRAIN after butterfly 127 is issued.
  - DRAIN → LAYER (next layer), or DONE after layer 6. With INTT_SCALE_EN, DRAIN → SCALE after layer 6.
  - SCALE → SDRAIN after the issue for address 255.
  - SDRAIN → DONE.
  - DONE → IDLE unconditionally.
- start while not IDLE is ignored.
- LAYER l (0..6), len = 2^(l+1), butterfly counter b = 0..127, one issue per cycle, rd_en = 1:
  - rd_addr_a = (b div len)*2*len + (b mod len); rd_addr_b = rd_addr_a + len.
  - zeta_idx = k. k is reset to 127 at start and decrements after each butterfly with b mod len = len-1.
  - Layer 0 uses k 127..64, layer 6 uses k = 1. Index 0 is never used.
- Issue cycle +1:
  - bf_even = rd_data_a, bf_odd = rd_data_b, bf_zeta = zeta_data.
  - wr_en_a = wr_en_b = 1, wr_addr_a/b = the read addresses delayed 1 cycle.
  - wr_data_a = bf_even_out, wr_data_b = bf_odd_out.
- DRAIN: one cycle with rd_en = 0. It performs the last write of the layer, so no read-during-write occurs across layers.
- In cycles with no write, bf_* outputs are 0.
- Timing without the optional feature:
  - start accepted at edge T. The first issue is in cycle T+1.
  - busy is high for 903 cycles (7×129).
  - done pulses in the cycle after the final DRAIN, and busy is low in that cycle.

Optional Feature:
Macro: INTT_SCALE_EN.
- When defined, the SCALE pass runs after layer 6 and multiplies every coefficient by N_INV, reusing the butterfly.
- SCALE behaviour:
  - i = 0..255, one per cycle: rd_addr_a = i, rd_en = 1.
  - Next cycle: bf_even = 0, bf_odd = rd_data_a, bf_zeta = N_INV, wr_en_a = 1, wr_addr_a = i, wr_data_a = bf_odd_out. wr_en_b stays 0.
- SDRAIN is one cycle. busy totals 903 + 257 = 1160 cycles.
- When undefined, the SCALE and SDRAIN states and the N_INV datapath are absent. Output is unscaled, as in pq-crystals without the final multiply.

Test Plan:
- Address trace: start pulse in cycle 0 →
  - cycle 1: rd_addr_a/b = 0/2, zeta_idx = 127
  - cycle 2: 1/3, zeta_idx = 127
  - cycle 3: 4/6, zeta_idx = 126
  - first layer-6 issue: 0/128, zeta_idx = 1
- All-zero RAM, start → RAM stays all zero; done exactly 904 cycles after start, or 1161 cycles with INTT_SCALE_EN.
- Random RAM preload (coefficients in [0,3328]), start → final RAM matches the Python reference INTT bit-exactly, with or without ×3303 per macro. The scaled INTT of the forward NTT of x returns x.
- start reasserted at cycles 5 and 500 while busy → ignored; exactly one done; result identical to the single-start run.
- rst asserted at cycle 300 → next cycle busy = 0, all write enables 0, and all outputs 0. A new start then completes with correct timing.
- Layer boundary: in each DRAIN cycle rd_en = 0 and wr_en = 1. No cycle has a read address equal to a write address.
